// File: rtl/gt_rx_pkg.sv
// Shared types and constants for the GT receive capture path (gt_rx_data_path).
package gt_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } gt_rx_state_t;

    localparam int          ERR_CNT_W         = 16;
    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hBCBC_BC50;

endpackage

// File: rtl/gt_rx_ram.sv
// Simple dual-port, read-first RAM with a registered read port; one instance per lane.
module gt_rx_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both ports update on the same edge, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/gt_rx_data_path.sv
// Receive capture engine: waits for the sync word on the master lane, then snapshots every lane into RAM.
// Optional per-lane sequence checker is built when GT_RX_SEQ_CHECK_EN is defined.
module gt_rx_data_path
    import gt_rx_pkg::*;
#(
    parameter int                          GT_CHN_NUM      = 6,
    parameter int                          USER_DATA_WIDTH = 32,
    parameter int                          MASTER_CHN      = 3,
    parameter int                          RAM_DEPTH       = 1024,
    parameter logic [USER_DATA_WIDTH-1:0]  SYNC_WORD       = SYNC_WORD_DEFAULT
) (
    input  logic                                  gt_clk,
    input  logic                                  gt_rstb,
    input  logic [GT_CHN_NUM*USER_DATA_WIDTH-1:0] gt_data,
    input  logic                                  gt_data_valid,
    input  logic                                  reg_start,
    input  logic                                  reg_reset,
    input  logic [31:0]                           reg_timeout,
    input  logic [2:0]                            ram_idx,
    input  logic [$clog2(RAM_DEPTH)-1:0]          ram_addr,
    output logic [USER_DATA_WIDTH-1:0]            ram_data,
    output logic                                  cap_busy,
    output logic                                  cap_done,
    output logic                                  sync_timeout,
    output logic [GT_CHN_NUM*ERR_CNT_W-1:0]       err_cnt
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int W  = USER_DATA_WIDTH;

    gt_rx_state_t   state, state_nxt;
    logic           start_d;
    logic           start_rise;
    logic           arm;
    logic           sync_hit;
    logic           timeout_hit;
    logic           wr_en;
    logic           last_write;
    logic [AW-1:0]  wr_ptr;
    logic [31:0]    to_cnt;
    logic [W-1:0]   rd_word [GT_CHN_NUM];
    logic [W-1:0]   rd_sel;
    logic [2:0]     ram_idx_q;

    assign start_rise  = reg_start & ~start_d;
    assign sync_hit    = gt_data_valid && (gt_data[MASTER_CHN*W +: W] == SYNC_WORD);
    assign timeout_hit = (reg_timeout != 32'd0) && (to_cnt == reg_timeout - 32'd1);
    assign wr_en       = (state == ST_CAPTURE) && gt_data_valid && !reg_reset;
    assign last_write  = wr_en && (wr_ptr == AW'(RAM_DEPTH - 1));

    always_ff @(posedge gt_clk or negedge gt_rstb) begin
        if (!gt_rstb) begin
            start_d <= 1'b0;
        end else begin
            start_d <= reg_start;
        end
    end

    always_ff @(posedge gt_clk or negedge gt_rstb) begin
        if (!gt_rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Soft clear outranks everything; start edges only count from IDLE or DONE.
    always_comb begin
        state_nxt = state;
        if (reg_reset) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start_rise) state_nxt = ST_SEARCH;
                ST_SEARCH: begin
                    if (sync_hit)         state_nxt = ST_CAPTURE;
                    else if (timeout_hit) state_nxt = ST_IDLE;
                end
                ST_CAPTURE: if (last_write) state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cap_busy = (state == ST_SEARCH) || (state == ST_CAPTURE);
        arm      = !reg_reset && start_rise && ((state == ST_IDLE) || (state == ST_DONE));
    end

    always_ff @(posedge gt_clk or negedge gt_rstb) begin
        if (!gt_rstb) begin
            wr_ptr       <= '0;
            to_cnt       <= '0;
            cap_done     <= 1'b0;
            sync_timeout <= 1'b0;
        end else if (reg_reset) begin
            wr_ptr       <= '0;
            to_cnt       <= '0;
            cap_done     <= 1'b0;
            sync_timeout <= 1'b0;
        end else begin
            if (arm) begin
                wr_ptr       <= '0;
                to_cnt       <= '0;
                cap_done     <= 1'b0;
                sync_timeout <= 1'b0;
            end
            if (state == ST_SEARCH) begin
                if (sync_hit) begin
                    wr_ptr <= '0;
                end else if (timeout_hit) begin
                    sync_timeout <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (last_write) begin
                    cap_done <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < GT_CHN_NUM; k++) begin : g_lane
        gt_rx_ram #(
            .DEPTH (RAM_DEPTH),
            .WIDTH (W)
        ) u_ram (
            .clk     (gt_clk),
            .wr_en   (wr_en),
            .wr_addr (wr_ptr),
            .wr_data (gt_data[k*W +: W]),
            .rd_addr (ram_addr),
            .rd_data (rd_word[k])
        );
    end

    // Lane select follows the RAM output stage, so the index is delayed to match.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < GT_CHN_NUM; k++) begin
            if (ram_idx_q == 3'(k)) begin
                rd_sel = rd_word[k];
            end
        end
    end

    always_ff @(posedge gt_clk or negedge gt_rstb) begin
        if (!gt_rstb) begin
            ram_idx_q <= '0;
            ram_data  <= '0;
        end else begin
            ram_idx_q <= ram_idx;
            ram_data  <= rd_sel;
        end
    end

`ifdef GT_RX_SEQ_CHECK_EN
    logic [W-1:0]         prev_word [GT_CHN_NUM];
    logic                 seeded;
    logic [ERR_CNT_W-1:0] err_q [GT_CHN_NUM];

    // The first captured word only seeds the reference; counters saturate.
    always_ff @(posedge gt_clk or negedge gt_rstb) begin
        if (!gt_rstb) begin
            seeded <= 1'b0;
            for (int k = 0; k < GT_CHN_NUM; k++) begin
                prev_word[k] <= '0;
                err_q[k]     <= '0;
            end
        end else if (reg_reset || arm) begin
            seeded <= 1'b0;
            for (int k = 0; k < GT_CHN_NUM; k++) begin
                err_q[k] <= '0;
            end
        end else if (wr_en) begin
            seeded <= 1'b1;
            for (int k = 0; k < GT_CHN_NUM; k++) begin
                prev_word[k] <= gt_data[k*W +: W];
                if (seeded && (gt_data[k*W +: W] != prev_word[k] + W'(1)) && (err_q[k] != '1)) begin
                    err_q[k] <= err_q[k] + ERR_CNT_W'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < GT_CHN_NUM; k++) begin : g_err
        assign err_cnt[k*ERR_CNT_W +: ERR_CNT_W] = err_q[k];
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_gt_rx_data_path.sv
// Self-checking bench for gt_rx_data_path: randomized capture traffic against a behavioural lane/RAM model.
`timescale 1ns/1ps
module tb_gt_rx_data_path;

    localparam int          N      = 6;
    localparam int          W      = 32;
    localparam int          DEPTH  = 1024;
    localparam int          AW     = 10;
    localparam int          MASTER = 3;
    localparam logic [31:0] SYNC   = 32'hBCBC_BC50;

    logic            gt_clk        = 1'b0;
    logic            gt_rstb       = 1'b0;
    logic [N*W-1:0]  gt_data       = '0;
    logic            gt_data_valid = 1'b0;
    logic            reg_start     = 1'b0;
    logic            reg_reset     = 1'b0;
    logic [31:0]     reg_timeout   = '0;
    logic [2:0]      ram_idx       = '0;
    logic [AW-1:0]   ram_addr      = '0;
    logic [W-1:0]    ram_data;
    logic            cap_busy;
    logic            cap_done;
    logic            sync_timeout;
    logic [N*16-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: what each lane RAM should hold and what each error counter should read.
    logic [W-1:0] mdl_mem [N][DEPTH];
    logic [W-1:0] mdl_prev [N];
    int           mdl_err [N];
    bit           mdl_seeded    = 0;
    bit           mdl_capturing = 0;
    int           wr_addr       = 0;
    int           coll_cnt      = 0;
    logic [W-1:0] coll_exp      = '0;

    always #5 gt_clk = ~gt_clk;

    gt_rx_data_path dut (
        .gt_clk        (gt_clk),
        .gt_rstb       (gt_rstb),
        .gt_data       (gt_data),
        .gt_data_valid (gt_data_valid),
        .reg_start     (reg_start),
        .reg_reset     (reg_reset),
        .reg_timeout   (reg_timeout),
        .ram_idx       (ram_idx),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .cap_busy      (cap_busy),
        .cap_done      (cap_done),
        .sync_timeout  (sync_timeout),
        .err_cnt       (err_cnt)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge gt_clk);
        #1;
        if (coll_cnt > 0) begin
            coll_cnt--;
            if (coll_cnt == 0) checkOutput("collision_read", ram_data, coll_exp);
        end
    endtask

    function automatic logic [W-1:0] laneWord(input int k, input int base, input int n);
        return W'(k << 24) + W'(base) + W'(n);
    endfunction

    function automatic logic [N*W-1:0] randData();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = $urandom;
        if (v[MASTER*W +: W] == SYNC) v[MASTER*W] = ~v[MASTER*W];
        return v;
    endfunction

    function automatic logic [N*16-1:0] expErr();
        logic [N*16-1:0] v;
        v = '0;
`ifdef GT_RX_SEQ_CHECK_EN
        for (int k = 0; k < N; k++) v[k*16 +: 16] = 16'(mdl_err[k]);
`endif
        return v;
    endfunction

    task automatic clearModelRun();
        wr_addr       = 0;
        mdl_capturing = 0;
        mdl_seeded    = 0;
        for (int k = 0; k < N; k++) mdl_err[k] = 0;
    endtask

    // Drive one cycle; while capturing, every valid word lands at the next address.
    task automatic applyStimulus(input logic valid, input logic [N*W-1:0] data);
        logic [W-1:0] word;
        gt_data_valid = valid;
        gt_data       = data;
        if (mdl_capturing && valid) begin
            for (int k = 0; k < N; k++) begin
                word = data[k*W +: W];
                if (mdl_seeded && word != mdl_prev[k] + 32'd1)
                    mdl_err[k] = (mdl_err[k] < 65535) ? mdl_err[k] + 1 : 65535;
                mdl_prev[k]         = word;
                mdl_mem[k][wr_addr] = word;
            end
            mdl_seeded = 1;
            wr_addr++;
            if (wr_addr == DEPTH) mdl_capturing = 0;
        end
        tick();
        gt_data_valid = 1'b0;
    endtask

    task automatic doStart();
        reg_start = 1'b1;
        tick();
        reg_start = 1'b0;
        clearModelRun();
        checkOutput("start_busy", cap_busy, 1'b1);
        checkOutput("start_done_clr", cap_done, 1'b0);
        checkOutput("start_timeout_clr", sync_timeout, 1'b0);
        checkOutput("start_err_clr", err_cnt, expErr());
    endtask

    task automatic sendSearch(input int count, input bit rand_valid);
        for (int i = 0; i < count; i++)
            applyStimulus(rand_valid ? 1'($urandom_range(0, 1)) : 1'b1, randData());
    endtask

    task automatic sendSync();
        logic [N*W-1:0] d;
        d = randData();
        d[MASTER*W +: W] = SYNC;
        applyStimulus(1'b1, d);
        mdl_capturing = 1;
    endtask

    task automatic captureWords(input int base, input int count, input bit gapped, input int coll_addr,
                                input int coll_lane, input int start_pulse_at, input int skip_a, input int skip_b);
        int cyc;
        int n;
        logic [N*W-1:0] d;
        cyc = 0;
        n   = 0;
        while (n < count) begin
            if (gapped && (cyc % 3 == 2)) begin
                applyStimulus(1'b0, randData());
            end else begin
                for (int k = 0; k < N; k++) d[k*W +: W] = laneWord(k, base, n);
                if (skip_a >= 0 && n >= skip_a) d[W +: W] = d[W +: W] + 32'd1;
                if (skip_b >= 0 && n >= skip_b) d[W +: W] = d[W +: W] + 32'd1;
                if (wr_addr == coll_addr) begin
                    ram_idx  = 3'(coll_lane);
                    ram_addr = AW'(coll_addr);
                    coll_exp = mdl_mem[coll_lane][coll_addr];
                    coll_cnt = 2;
                end
                if (wr_addr == DEPTH - 1) begin
                    checkOutput("done_before_last", cap_done, 1'b0);
                    checkOutput("busy_before_last", cap_busy, 1'b1);
                end
                if (n == start_pulse_at) reg_start = 1'b1;
                applyStimulus(1'b1, d);
                reg_start = 1'b0;
                n++;
            end
            cyc++;
        end
    endtask

    task automatic readCheck(input string tag, input int lane, input int addr);
        logic [W-1:0] expv;
        ram_idx  = 3'(lane);
        ram_addr = AW'(addr);
        tick();
        tick();
        expv = (lane < N) ? mdl_mem[lane][addr] : '0;
        checkOutput(tag, ram_data, expv);
    endtask

    task automatic randomReads(input int count);
        for (int i = 0; i < count; i++) readCheck("rand_read", $urandom_range(0, 7), $urandom_range(0, DEPTH - 1));
    endtask

    initial begin
        int base;
        int i1;
        int i2;
        clearModelRun();

        // Reset values while gt_rstb is held low.
        tick();
        tick();
        checkOutput("rst_ram_data", ram_data, 32'h0);
        checkOutput("rst_busy", cap_busy, 1'b0);
        checkOutput("rst_done", cap_done, 1'b0);
        checkOutput("rst_timeout", sync_timeout, 1'b0);
        checkOutput("rst_err", err_cnt, '0);
        gt_rstb = 1'b1;
        tick();

        // Basic capture with a start edge thrown in mid-capture that must be ignored.
        doStart();
        sendSearch(5, 0);
        sendSync();
        captureWords(0, DEPTH, 0, -1, 0, 300, -1, -1);
        checkOutput("basic_done", cap_done, 1'b1);
        checkOutput("basic_busy", cap_busy, 1'b0);
        checkOutput("basic_err", err_cnt, expErr());
        ram_idx  = 3'd2;
        ram_addr = AW'(5);
        tick();
        tick();
        checkOutput("basic_lane2_addr5", ram_data, 32'h0200_0005);
        randomReads(8);
        readCheck("bad_lane6", 6, 17);

        // Gapped valid with a read/write collision on a random lane and address.
        doStart();
        sendSearch($urandom_range(1, 8), 1);
        sendSync();
        base = $urandom_range(1, 32'h007F_FFFF);
        captureWords(base, DEPTH, 1, $urandom_range(100, 900), $urandom_range(0, N - 1), -1, -1, -1);
        checkOutput("gap_done", cap_done, 1'b1);
        checkOutput("gap_busy", cap_busy, 1'b0);
        readCheck("gap_addr0", $urandom_range(0, N - 1), 0);
        readCheck("gap_addr_last", $urandom_range(0, N - 1), DEPTH - 1);
        randomReads(6);

        // Search timeout of 100 cycles, then a restart that clears the flag.
        reg_timeout = 32'd100;
        doStart();
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randData());
            if (i == 99) begin
                checkOutput("to_busy_99", cap_busy, 1'b1);
                checkOutput("to_flag_99", sync_timeout, 1'b0);
            end
        end
        checkOutput("to_busy_100", cap_busy, 1'b0);
        checkOutput("to_flag_100", sync_timeout, 1'b1);
        checkOutput("to_done", cap_done, 1'b0);
        doStart();
        reg_timeout = 32'd0;
        sendSearch(150, 1);
        checkOutput("no_to_busy", cap_busy, 1'b1);
        checkOutput("no_to_flag", sync_timeout, 1'b0);
        reg_reset = 1'b1;
        tick();
        reg_reset = 1'b0;
        checkOutput("soft_clr_busy", cap_busy, 1'b0);

        // Soft clear at write 500, then start+clear together, then a full recapture with lane 1 slips.
        doStart();
        sendSync();
        base = $urandom_range(1, 32'h007F_FFFF);
        captureWords(base, 500, 0, -1, 0, -1, -1, -1);
        reg_reset = 1'b1;
        applyStimulus(1'b0, randData());
        reg_reset = 1'b0;
        clearModelRun();
        checkOutput("mid_rst_busy", cap_busy, 1'b0);
        checkOutput("mid_rst_done", cap_done, 1'b0);
        checkOutput("mid_rst_timeout", sync_timeout, 1'b0);
        checkOutput("mid_rst_err", err_cnt, '0);
        reg_start = 1'b1;
        reg_reset = 1'b1;
        tick();
        reg_start = 1'b0;
        reg_reset = 1'b0;
        tick();
        checkOutput("start_with_clr_busy", cap_busy, 1'b0);

        doStart();
        sendSearch($urandom_range(1, 6), 1);
        sendSync();
        base = $urandom_range(1, 32'h007F_FFFF);
        i1   = $urandom_range(10, 400);
        i2   = $urandom_range(500, 1000);
        captureWords(base, DEPTH, 0, $urandom_range(100, 900), $urandom_range(0, N - 1), -1, i1, i2);
        checkOutput("seq_done", cap_done, 1'b1);
        checkOutput("seq_err_all", err_cnt, expErr());
`ifdef GT_RX_SEQ_CHECK_EN
        checkOutput("seq_err_lane1", err_cnt[31:16], 16'd2);
`else
        checkOutput("seq_err_off", err_cnt, '0);
`endif
        readCheck("recap_addr0", $urandom_range(0, N - 1), 0);
        readCheck("recap_addr500", 1, 500);
        randomReads(4);

        // A fresh start clears the error counters.
        doStart();

        // Asynchronous reset mid-search takes effect without a clock edge.
        @(posedge gt_clk);
        #2;
        gt_rstb = 1'b0;
        #1;
        checkOutput("async_rst_busy", cap_busy, 1'b0);
        checkOutput("async_rst_err", err_cnt, '0);
        tick();
        gt_rstb = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gt_rx_data_path.md
# gt_rx_data_path

Receive-side capture engine for the 6-lane GTY link; the counterpart of the transmit path `gt_data_path`. It takes parallel per-lane user words from the GT RX wrapper and arms on a register start. It aligns all lanes to a sync word seen on the master lane, then records a fixed-depth snapshot of every lane into per-lane RAM, which software reads back through the register map.

## Interface
- `GT_CHN_NUM`, 6, number of lanes.
- `USER_DATA_WIDTH`, 32, bits per lane word.
- `MASTER_CHN`, 3, lane on which the sync word is searched.
- `RAM_DEPTH`, 1024, words captured per lane; power of two.
- `SYNC_WORD`, 32'hBCBC_BC50, alignment marker.
- `gt_clk` in 1: GT user clock, 187.5 MHz; the only clock.
- `gt_rstb` in 1: reset, asynchronous, active-low.
- `gt_data` in GT_CHN_NUM*USER_DATA_WIDTH: lane words; lane k occupies bits [k*W +: W].
- `gt_data_valid` in 1: qualifies `gt_data`.
- `reg_start` in 1: level; its rising edge arms a capture.
- `reg_reset` in 1: synchronous soft clear, level.
- `reg_timeout` in 32: SEARCH timeout in cycles; 0 means no timeout.
- `ram_idx` in 3: lane select for readback.
- `ram_addr` in $clog2(RAM_DEPTH): readback address.
- `ram_data` out USER_DATA_WIDTH: readback word.
- `cap_busy` out 1: high in SEARCH or CAPTURE.
- `cap_done` out 1: capture complete, sticky.
- `sync_timeout` out 1: sync not found, sticky.
- `err_cnt` out GT_CHN_NUM*16: per-lane sequence-error counters.

## Operation
- FSM states: IDLE, SEARCH, CAPTURE, DONE.
- IDLE: on a `reg_start` rising edge, clear `cap_done`, `sync_timeout` and the timeout counter, then go to SEARCH.
- SEARCH: go to CAPTURE on a cycle with `gt_data_valid`=1 and master lane == SYNC_WORD. The sync word itself is not stored.
- SEARCH timeout: if `reg_timeout`≠0 and the cycle count reaches `reg_timeout`, set `sync_timeout` and go to IDLE.
- CAPTURE: each valid cycle writes every lane's word to its RAM at the write pointer, then increments the pointer. Invalid cycles write nothing.
- CAPTURE end: after write RAM_DEPTH-1 go to DONE and set `cap_done`. There is no wrap-around and no overwrite.
- DONE: a `reg_start` rising edge behaves as in IDLE. Other inputs are ignored.
- A `reg_start` edge while in SEARCH or CAPTURE is ignored.
- `reg_reset`=1 forces IDLE and clears the flags, the pointer and `err_cnt`. It has priority over `reg_start` in the same cycle. RAM contents are retained.
- `gt_rstb` low mid-operation: same effect as `reg_reset`, applied asynchronously. RAM is not initialised.
- Readback is allowed in any state. Each RAM is read-first: a read colliding with a write returns the old word. A `ram_idx` ≥ GT_CHN_NUM returns 0.

## Timing
- Start edge registered at cycle N: `cap_busy`=1 from N+1.
- Sync-word cycle M: the first valid word after M is written to address 0.
- The last write happens at cycle L: state is DONE and `cap_done`=1 at L+1, and `cap_busy`=0 at the same cycle.
- Readback latency is 2 cycles: RAM output register, then lane-mux register.
- Reset values: `ram_data`=0, `cap_busy`=0, `cap_done`=0, `sync_timeout`=0, `err_cnt`=0, state IDLE.

## Configuration
- Macro: `GT_RX_SEQ_CHECK_EN`.
- Defined: during CAPTURE, each lane's word must equal the previous valid word of that lane +1, modulo 2^W. The first captured word only seeds the reference.
- Each mismatch increments that lane's 16-bit counter, which saturates at 16'hFFFF. Counters clear on a start edge.
- Not defined: `err_cnt` is tied to 0 and no checker logic is built.

## Structure
- Package `gt_rx_pkg` holds the FSM state enum, the `ERR_CNT_W`=16 constant and the default `SYNC_WORD`.
- Sub-module `gt_rx_ram` is a simple dual-port, read-first, registered-output RAM of depth RAM_DEPTH × W. It is instantiated once per lane in a generate loop.

## Test plan
- **Basic capture:** start, then 5 idle words, then SYNC_WORD on lane 3, then lanes k carrying k<<24|n, n=0.. → `cap_done` 1024 valid cycles after sync. Readback lane 2 addr 5 = 32'h0200_0005 after 2 cycles.
- **Gapped valid:** deassert `gt_data_valid` every 3rd cycle → addresses stay contiguous and `cap_done` is delayed by the number of gaps.
- **Timeout:** `reg_timeout`=100 with no sync → `sync_timeout`=1 and `cap_busy`=0 at cycle 101 after start. A new start clears `sync_timeout`.
- **Reset mid-capture:** `reg_reset` at write 500 → IDLE and flags 0. The next start recaptures from address 0. Start and `reg_reset` in the same cycle → stays IDLE.
- **Sequence check (macro on):** inject a wrong word on lane 1 twice → `err_cnt[31:16]`=2 and all other lanes 0. With the macro off → `err_cnt`=0.
- **Collision:** read the address being written during CAPTURE → returns the prior content.
